// File: rtl/proc_dbg_pkg.sv
// Shared types and default widths for the processor run/halt/step debug block.
// Pure declarations; no timing or flow-control behaviour.
package proc_dbg_pkg;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } run_state_t;

  localparam int PC_W_DEF   = 32;
  localparam int CYC_W_DEF  = 32;
  localparam int STEP_W_DEF = 8;

endpackage

// File: rtl/proc_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// One-cycle update latency, no backpressure (holds at all-ones instead of wrapping).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run/halt/single-step sequencer gating the core's commit enable; optional PC breakpoint
// under PROC_RUN_BREAKPOINT_EN. Requests act the next cycle; enable/bp_stop are combinational.
module proc_run_ctrl
  import proc_dbg_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int CYC_W  = CYC_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              clr_cnt,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_valid,
  output logic              enable,
  output logic [1:0]        state,
  output logic              done,
  output logic              bp_hit,
  output logic [CYC_W-1:0]  icount
);

  run_state_t        st;
  run_state_t        st_nxt;
  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] cnt_nxt;
  logic              active;
  logic              accept;
  logic              bp_stop;

  assign active = (st == S_RUN) || (st == S_STEP);
  assign enable = active & ~bp_stop;
  assign state  = st;
  assign accept = (st == S_HALT) & ~halt_req & (step_req | run_req);

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      S_HALT: begin
        if (!halt_req) begin
          if (step_req) begin
            st_nxt  = S_STEP;
            cnt_nxt = (step_n == '0) ? STEP_W'(1) : step_n;
          end else if (run_req) begin
            st_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (halt_req || bp_stop) st_nxt = S_HALT;
      end
      S_STEP: begin
        if (enable) cnt_nxt = cnt - STEP_W'(1);
        if (halt_req || bp_stop || (enable && (cnt == STEP_W'(1)))) st_nxt = S_HALT;
      end
      default: st_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= S_HALT;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      done <= active && (st_nxt == S_HALT);
    end
  end

`ifdef PROC_RUN_BREAKPOINT_EN
  logic skip;

  // skip lets a resume from a breakpoint commit the instruction at bp_addr once
  assign bp_stop = active & bp_valid & (pc == bp_addr) & ~skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip   <= 1'b0;
      bp_hit <= 1'b0;
    end else begin
      if (accept)      skip <= 1'b1;
      else if (enable) skip <= 1'b0;
      if (accept)       bp_hit <= 1'b0;
      else if (bp_stop) bp_hit <= 1'b1;
    end
  end
`else
  logic unused_bp;

  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_valid, accept};
`endif

  sat_counter #(.W(CYC_W)) u_icount (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (enable),
    .cnt   (icount)
  );

endmodule
